// File: rtl/chip8_pkg.sv
// Shared types and constants for the Chip8 display engine.
package chip8_pkg;

    localparam int unsigned SCREEN_W = 64;
    localparam int unsigned SCREEN_H = 32;
    localparam int unsigned FB_BITS  = SCREEN_W * SCREEN_H;
    localparam int unsigned SPRITE_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetch,
        StDraw,
        StDone
    } state_e;

    // Sprite bit 7 is the leftmost pixel; reverse so column offset b sits at bit b.
    function automatic logic [SPRITE_W-1:0] sprite_to_cols(input logic [SPRITE_W-1:0] b);
        logic [SPRITE_W-1:0] r;
        for (int i = 0; i < SPRITE_W; i++) begin
            r[i] = b[SPRITE_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/chip8_row_blit.sv
// Combinational XOR blit of one sprite byte into one framebuffer row.
// CHIP8_SPRITE_WRAP_EN: when defined, pixels past the right edge wrap to column 0;
// otherwise they are clipped.
module chip8_row_blit
    import chip8_pkg::*;
(
    input  logic [SCREEN_W-1:0]         i_row,
    input  logic [SPRITE_W-1:0]         i_byte,
    input  logic [$clog2(SCREEN_W)-1:0] i_x0,
    input  logic                        i_row_valid,
    output logic [SCREEN_W-1:0]         o_row,
    output logic                        o_collision
);

    logic [SPRITE_W-1:0] w_cols;
    logic [SCREEN_W-1:0] w_mask_raw;
    logic [SCREEN_W-1:0] w_mask;

    assign w_cols = sprite_to_cols(i_byte);

`ifdef CHIP8_SPRITE_WRAP_EN
    // Shift into a widened vector, then fold the overflow back onto the low columns.
    logic [SCREEN_W+SPRITE_W-1:0] w_wide;
    assign w_wide     = {{SCREEN_W{1'b0}}, w_cols} << i_x0;
    assign w_mask_raw = w_wide[SCREEN_W-1:0]
                      | {{(SCREEN_W-SPRITE_W){1'b0}}, w_wide[SCREEN_W +: SPRITE_W]};
`else
    // Bits shifted past the top column fall off: that is the clipping.
    assign w_mask_raw = {{(SCREEN_W-SPRITE_W){1'b0}}, w_cols} << i_x0;
`endif

    assign w_mask      = i_row_valid ? w_mask_raw : '0;
    assign o_row       = i_row ^ w_mask;
    assign o_collision = |(i_row & w_mask);

endmodule

// File: rtl/chip8_sprite_draw.sv
// Chip8 display engine: owns the 64x32 framebuffer, runs CLS and DXYN, fetches
// sprite rows through a one-cycle-latency read port.
// CHIP8_SPRITE_WRAP_EN: when defined, sprite lines past the bottom wrap to line 0
// (columns wrap inside chip8_row_blit); otherwise they are clipped.
module chip8_sprite_draw
    import chip8_pkg::*;
#(
    parameter int unsigned MEM_AW = 12
) (
    input  logic                SYS_CLK,
    input  logic                RST_N,
    input  logic                start,
    input  logic                clear,
    input  logic [7:0]          x,
    input  logic [7:0]          y,
    input  logic [3:0]          n,
    input  logic [MEM_AW-1:0]   i_addr,
    output logic                mem_en,
    output logic [MEM_AW-1:0]   mem_addr,
    input  logic [7:0]          mem_rdata,
    output logic                busy,
    output logic                done,
    output logic                collision,
    output logic                vidclear,
    output logic [FB_BITS-1:0]  vidout
);

    state_e              r_state;
    logic [FB_BITS-1:0]  r_fb;
    logic [5:0]          r_x0;
    logic [4:0]          r_y0;
    logic [3:0]          r_n;
    logic [MEM_AW-1:0]   r_base;
    logic [4:0]          r_row;       // sprite row in DRAW/FETCH, screen line in CLEAR
    logic                r_coll_acc;
    logic                r_collision;
    logic                r_done;
    logic                r_vidclear;
    logic                r_mem_en;
    logic [MEM_AW-1:0]   r_mem_addr;

    logic [4:0]          w_line;
    logic                w_line_ok;
    logic [SCREEN_W-1:0] w_fb_row;
    logic [SCREEN_W-1:0] w_new_row;
    logic                w_row_coll;
    logic                w_last_row;

`ifdef CHIP8_SPRITE_WRAP_EN
    // 5-bit sum truncates, giving the mod-32 wrap for free.
    assign w_line    = r_y0 + r_row;
    assign w_line_ok = 1'b1;
`else
    logic [5:0] w_line_full;
    assign w_line_full = {1'b0, r_y0} + {1'b0, r_row};
    assign w_line      = w_line_full[4:0];
    assign w_line_ok   = ~w_line_full[5];
`endif

    assign w_fb_row   = r_fb[{w_line, 6'b0} +: SCREEN_W];
    assign w_last_row = (r_row[3:0] == (r_n - 4'd1));

    chip8_row_blit u_blit (
        .i_row       (w_fb_row),
        .i_byte      (mem_rdata),
        .i_x0        (r_x0),
        .i_row_valid (w_line_ok),
        .o_row       (w_new_row),
        .o_collision (w_row_coll)
    );

    // Control FSM together with the framebuffer and all registered outputs
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= StIdle;
            r_fb        <= '0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_n         <= '0;
            r_base      <= '0;
            r_row       <= '0;
            r_coll_acc  <= 1'b0;
            r_collision <= 1'b0;
            r_done      <= 1'b0;
            r_vidclear  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_vidclear <= 1'b0;
            r_mem_en   <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (clear) begin
                        // Clear wins; a coincident start is dropped.
                        r_row   <= '0;
                        r_state <= StClear;
                    end else if (start) begin
                        r_collision <= 1'b0;
                        r_coll_acc  <= 1'b0;
                        if (n != 4'd0) begin
                            r_x0       <= 6'(x % 8'd64);
                            r_y0       <= 5'(y % 8'd32);
                            r_n        <= n;
                            r_base     <= i_addr;
                            r_row      <= '0;
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= i_addr;
                            r_state    <= StFetch;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                end
                StClear: begin
                    r_fb[{r_row, 6'b0} +: SCREEN_W] <= '0;
                    if (r_row == 5'(SCREEN_H - 1)) begin
                        r_vidclear <= 1'b1;
                        r_state    <= StIdle;
                    end else begin
                        r_row <= r_row + 5'd1;
                    end
                end
                StFetch: begin
                    r_state <= StDraw;
                end
                StDraw: begin
                    if (w_line_ok) begin
                        r_fb[{w_line, 6'b0} +: SCREEN_W] <= w_new_row;
                    end
                    if (w_last_row) begin
                        r_collision <= r_coll_acc | w_row_coll;
                        r_done      <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_coll_acc <= r_coll_acc | w_row_coll;
                        r_row      <= r_row + 5'd1;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= r_base + MEM_AW'(r_row + 5'd1);
                        r_state    <= StFetch;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy      = (r_state != StIdle);
    assign done      = r_done;
    assign collision = r_collision;
    assign vidclear  = r_vidclear;
    assign mem_en    = r_mem_en;
    assign mem_addr  = r_mem_addr;
    assign vidout    = r_fb;

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Randomized self-checking bench for chip8_sprite_draw against a pixel-level model.
module tb_chip8_sprite_draw;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         clear = 1'b0;
    logic [7:0]   x = '0;
    logic [7:0]   y = '0;
    logic [3:0]   n = '0;
    logic [11:0]  i_addr = '0;
    logic         mem_en;
    logic [11:0]  mem_addr;
    logic [7:0]   mem_rdata = '0;
    logic         busy, done, collision, vidclear;
    logic [2047:0] vidout;

    logic [7:0]   mem [4096];
    logic [63:0]  m_fb [32];
    bit           last_coll;
    int           n_total = 0;
    int           n_bad = 0;

    chip8_sprite_draw #(.MEM_AW(12)) dut (
        .SYS_CLK   (clk),
        .RST_N     (rst_n),
        .start     (start),
        .clear     (clear),
        .x         (x),
        .y         (y),
        .n         (n),
        .i_addr    (i_addr),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .vidclear  (vidclear),
        .vidout    (vidout)
    );

    always #5 clk = ~clk;

    // Read port: data valid the cycle after the strobe.
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_fb(input string tag);
        for (int r = 0; r < 32; r++)
            check_eq($sformatf("%s row%0d", tag, r), vidout[r*64 +: 64], m_fb[r]);
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) m_fb[r] = '0;
    endtask

    // Pixel-by-pixel reference of DXYN.
    task automatic model_draw(input logic [7:0] xv, input logic [7:0] yv, input logic [3:0] nv,
                              input logic [11:0] av, output bit coll);
        int x0, y0, col, line;
        logic [7:0] b;
        x0 = int'(xv) % 64;
        y0 = int'(yv) % 32;
        coll = 0;
        for (int r = 0; r < int'(nv); r++) begin
            b = mem[(int'(av) + r) % 4096];
            for (int k = 0; k < 8; k++) begin
                if (b[7-k]) begin
                    col  = x0 + k;
                    line = y0 + r;
`ifdef CHIP8_SPRITE_WRAP_EN
                    col  = col % 64;
                    line = line % 32;
`endif
                    if (col < 64 && line < 32) begin
                        if (m_fb[line][col]) coll = 1;
                        m_fb[line][col] = ~m_fb[line][col];
                    end
                end
            end
        end
    endtask

    task automatic draw(input logic [7:0] xv, input logic [7:0] yv, input logic [3:0] nv,
                        input logic [11:0] av, input bit poke);
        int c, fetches;
        bit seen, coll;
        @(negedge clk);
        x = xv; y = yv; n = nv; i_addr = av; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x = ~xv; y = ~yv; n = 4'd1; i_addr = ~av;  // engine must use its latched copy
        c = 1; fetches = 0; seen = 0;
        while (!seen && c <= 64) begin
            if (mem_en) begin
                check_eq("mem_addr", mem_addr, (int'(av) + fetches) % 4096);
                fetches++;
            end
            if (done) seen = 1;
            else begin
                if (poke && c == 2) begin
                    if ($urandom_range(1) == 1) start = 1'b1;
                    else clear = 1'b1;
                end else begin
                    start = 1'b0; clear = 1'b0;
                end
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0; clear = 1'b0;
        model_draw(xv, yv, nv, av, coll);
        last_coll = coll;
        check_eq("done_seen", seen, 1);
        check_eq("done_lat", c, (nv == 0) ? 1 : 2 * int'(nv) + 1);
        check_eq("fetches", fetches, nv);
        check_eq("collision", collision, coll);
        check_eq("busy_done", busy, 1);
        check_fb("fb_draw");
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        check_eq("busy_idle", busy, 0);
        check_eq("coll_hold", collision, coll);
    endtask

    task automatic do_clear(input bit with_start);
        int c;
        bit seen, saw_done, saw_mem;
        @(negedge clk);
        clear = 1'b1; start = with_start; x = 8'd3; y = 8'd4; n = 4'd3; i_addr = 12'h050;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        c = 1; seen = 0; saw_done = 0; saw_mem = 0;
        while (!seen && c <= 64) begin
            if (done) saw_done = 1;
            if (mem_en) saw_mem = 1;
            if (vidclear) seen = 1;
            else begin
                check_eq($sformatf("clr_busy c%0d", c), busy, 1);
                @(negedge clk);
                c++;
            end
        end
        model_clear();
        check_eq("vidclear_seen", seen, 1);
        check_eq("vidclear_lat", c, 33);
        check_eq("clr_no_done", saw_done, 0);
        check_eq("clr_no_mem", saw_mem, 0);
        check_eq("clr_coll_hold", collision, last_coll);
        check_fb("fb_clear");
        @(negedge clk);
        check_eq("vidclear_pulse", vidclear, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_coll"}, collision, 0);
        check_eq({tag, "_vclr"}, vidclear, 0);
        check_eq({tag, "_mem_en"}, mem_en, 0);
        check_eq({tag, "_mem_addr"}, mem_addr, 0);
        check_fb(tag);
    endtask

    task automatic reset_mid_draw();
        bit seen;
        @(negedge clk);
        x = 8'd10; y = 8'd5; n = 4'd8; i_addr = 12'h123; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        last_coll = 0;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check_eq("rst_no_done", seen, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        mem[12'h300] = 8'hFF; mem[12'h301] = 8'hFF;
        mem[12'h400] = 8'h80;
        model_clear();
        last_coll = 0;

        // Reset state, held and released
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_rel");

        // Font "0" drawn, then erased by an identical draw
        draw(8'd0, 8'd0, 4'd5, 12'h050, 0);
        check_eq("font_r0", vidout[3:0], 4'hF);
        check_eq("font_r1", {vidout[67], vidout[64]}, 2'b11);
        check_eq("font_coll0", collision, 0);
        draw(8'd0, 8'd0, 4'd5, 12'h050, 0);
        check_eq("font_coll1", collision, 1);

        // n = 0: immediate done, clears collision, no fetch
        draw(8'd7, 8'd9, 4'd0, 12'h000, 0);
        check_eq("n0_coll", collision, 0);

        // Corner clip / wrap
        draw(8'd62, 8'd31, 4'd2, 12'h300, 0);
        check_eq("px_31_62", vidout[31*64+62], 1);
        check_eq("px_31_63", vidout[31*64+63], 1);
`ifdef CHIP8_SPRITE_WRAP_EN
        check_eq("px_0_0", vidout[0], 1);
`else
        check_eq("px_0_0", vidout[0], 0);
`endif

        // Start coordinates reduced mod screen size
        draw(8'd200, 8'd40, 4'd1, 12'h400, 0);
        check_eq("px_8_8", vidout[8*64+8], 1);

        // Random draws, some with an ignored start/clear while busy
        for (int t = 0; t < 20; t++)
            draw(8'($urandom), 8'($urandom), 4'($urandom), 12'($urandom), ($urandom_range(2) == 0));

        reset_mid_draw();

        for (int t = 0; t < 10; t++)
            draw(8'($urandom), 8'($urandom), 4'($urandom_range(15, 6)), 12'($urandom), 1'b0);

        // Clear with a simultaneous start that must be dropped
        do_clear(1'b1);
        draw(8'($urandom), 8'($urandom), 4'd4, 12'($urandom), 1'b0);
        do_clear(1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
